line_tx: RTL and testbench

Serial valve-command transmitter for the main-board side of the valve-board link. It accepts a 48-bit valve word over a valid/ready handshake and drives the three-wire frame line_sen / line_sclk / line_sdata consumed by the valve-board receiver. Bits go out LSB first and are sampled by the receiver on the line_sclk rising edge. The block sits between the frame scheduler and the board connector pins.

---
 rtl/line_tx.sv | 143 ++++++++++++++
 tb/tb_line_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/line_tx.sv
// line_tx: serial valve-command transmitter. Takes one DATA_W word per
// handshake and shifts it out LSB first on a sen/sclk/sdata frame.
// Every pin is a flop fed from the current state. The pins therefore trail
// the FSM by one cycle, and no input reaches a pin combinationally.
module line_tx #(
  parameter int DATA_W = 48,
  parameter int T_LEAD = 2,
  parameter int T_LO   = 10,
  parameter int T_HI   = 10,
  parameter int T_TAIL = 2,
  parameter int T_GAP  = 4,
  parameter bit INVERT = 1'b1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_done,
  output logic              line_sen,
  output logic              line_sclk,
  output logic              line_sdata
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max2(max2(max2(T_LEAD, T_LO), max2(T_HI, T_TAIL)), T_GAP);
  localparam int CW   = $clog2(TMAX + 1);
  localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] LEAD_END = CW'(T_LEAD - 1);
  localparam logic [CW-1:0] LO_END   = CW'(T_LO - 1);
  localparam logic [CW-1:0] HI_END   = CW'(T_HI - 1);
  localparam logic [CW-1:0] TAIL_END = CW'(T_TAIL - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(T_GAP - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LEAD, BIT_LO, BIT_HI, TAIL, GAP} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                sen_q, sen_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                accept;

  assign accept     = tx_valid && ready_q;
  assign tx_ready   = ready_q;
  assign tx_done    = done_q;
  assign line_sen   = sen_q;
  assign line_sclk  = sclk_q;
  assign line_sdata = sdata_q;

  // Next-state, phase/bit counters, shift register and pin values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          shreg_d = tx_data;
          bit_d   = '0;
          state_d = LEAD;
        end
      end
      LEAD: if (cnt_q == LEAD_END) begin
        cnt_d   = '0;
        state_d = BIT_LO;
      end
      BIT_LO: if (cnt_q == LO_END) begin
        cnt_d   = '0;
        state_d = BIT_HI;
      end
      BIT_HI: if (cnt_q == HI_END) begin
        cnt_d = '0;
        if (bit_q != LAST_BIT) begin
          // Shift only after the hold phase, so sdata stays put while sclk is high.
          bit_d   = bit_q + 1'b1;
          shreg_d = shreg_q >> 1;
          state_d = BIT_LO;
        end else begin
          state_d = TAIL;
        end
      end
      TAIL: if (cnt_q == TAIL_END) begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: if (cnt_q == GAP_END) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Ready trails the state by one cycle and drops the cycle a word is taken.
    // This gives the one idle cycle after GAP before the next word can be accepted.
    ready_d = (state_q == IDLE) && !accept;
    sen_d   = (state_q == LEAD) || (state_q == BIT_LO) ||
              (state_q == BIT_HI) || (state_q == TAIL);
    sclk_d  = (state_q == BIT_HI);
    sdata_d = ((state_q == BIT_LO) || (state_q == BIT_HI)) ? (shreg_q[0] ^ INVERT) : 1'b1;
    done_d  = (state_q == GAP) && (cnt_q == '0);
  end

  // State and output registers; reset parks the link idle and drops any frame in progress.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      sen_q   <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      sen_q   <= sen_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
    end
  end

endmodule

// File: tb/tb_line_tx.sv
// tb_line_tx: two line_tx instances. One uses the default 48-bit inverted link.
// The other is an 8-bit, all-phases-1, non-inverted variant.
// Each cycle, the expected pin values are computed from the number of cycles
// since the last accepted word.
module tb_line_tx;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic             rst_n = 1'b0;
  logic [1:0][47:0] dat   = '0;
  logic [1:0]       vld   = '0;
  logic [1:0]       rdy, done, sen, sclk, sdata;

  line_tx #(.DATA_W(48), .T_LEAD(2), .T_LO(10), .T_HI(10), .T_TAIL(2), .T_GAP(4),
            .INVERT(1'b1)) u_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx_done(done[0]), .line_sen(sen[0]), .line_sclk(sclk[0]),
    .line_sdata(sdata[0]));

  line_tx #(.DATA_W(8), .T_LEAD(1), .T_LO(1), .T_HI(1), .T_TAIL(1), .T_GAP(1),
            .INVERT(1'b0)) u_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .tx_data(dat[1][7:0]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx_done(done[1]), .line_sen(sen[1]), .line_sclk(sclk[1]),
    .line_sdata(sdata[1]));

  int P_DW[2]   = '{48, 8};
  int P_LEAD[2] = '{2, 1};
  int P_LO[2]   = '{10, 1};
  int P_HI[2]   = '{10, 1};
  int P_TAIL[2] = '{2, 1};
  int P_GAP[2]  = '{4, 1};
  bit P_INV[2]  = '{1'b1, 1'b0};
  localparam int INF = 1 << 30;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    else n_pass++;
  endtask

  // Pins expected jj cycles after the accepting edge: {sen, sclk, sdata, done, ready}.
  function automatic logic [4:0] expect_out(input int d, input int jj, input logic [47:0] w,
                                            input int ps);
    int per, f, p, q;
    logic s, c, sd, dn, r;
    per = P_LO[d] + P_HI[d];
    f   = P_LEAD[d] + P_DW[d] * per + P_TAIL[d];
    s = 0; c = 0; sd = 1;
    if (jj >= 1 && jj <= f) begin
      s = 1;
      p = jj - 1;
      if (p >= P_LEAD[d] && p < P_LEAD[d] + P_DW[d] * per) begin
        q  = p - P_LEAD[d];
        c  = (q % per) >= P_LO[d];
        sd = w[q / per] ^ P_INV[d];
      end
    end
    dn = (jj == f + 1);
    r  = (ps >= 1) && (jj >= f + P_GAP[d] + 1);
    return {s, c, sd, dn, r};
  endfunction

  // Model state and receiver state.
  int          j[2], post[2], rlen[2], rrise[2], rlow[2];
  int          last_len[2], last_rise[2], last_low[2], done_cnt[2];
  bit          pend[2];
  logic [47:0] mw[2], pw[2], rword[2];
  logic        psclk[2], psen[2];
  logic [47:0] hist_a[$], hist_b[$];

  // Compare process: checks the model each cycle and decodes frames the way the receiver does.
  initial begin
    logic [4:0] e;
    for (int d = 0; d < 2; d++) begin
      j[d] = INF; post[d] = 0; pend[d] = 0; done_cnt[d] = 0;
      rlen[d] = 0; rrise[d] = 0; rlow[d] = 0; rword[d] = '0; psclk[d] = 0; psen[d] = 0;
      last_len[d] = 0; last_rise[d] = 0; last_low[d] = 0;
    end
    forever begin
      @(negedge sys_clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          chk(d == 0 ? "rst_pins_a" : "rst_pins_b",
              {sen[d], sclk[d], sdata[d], done[d], rdy[d]}, 5'b00100);
          j[d] = INF; post[d] = 0; pend[d] = 0;
          rlen[d] = 0; rrise[d] = 0; rword[d] = '0; psclk[d] = 0; psen[d] = 0; rlow[d] = 0;
        end else begin
          post[d]++;
          if (pend[d]) begin j[d] = 0; mw[d] = pw[d]; end
          else if (j[d] < INF) j[d]++;
          e = expect_out(d, j[d], mw[d], post[d]);
          chk(d == 0 ? "pins_a" : "pins_b", {sen[d], sclk[d], sdata[d], done[d], rdy[d]}, e);
          pend[d] = vld[d] && e[0];
          pw[d]   = dat[d];
          if (sen[d]) rlen[d]++; else rlow[d]++;
          if (sen[d] && sclk[d] && !psclk[d]) begin
            if (rrise[d] < 48) rword[d][rrise[d]] = sdata[d] ^ P_INV[d];
            rrise[d]++;
          end
          if (sen[d] && !psen[d]) begin last_low[d] = rlow[d]; end
          if (!sen[d] && psen[d]) begin
            last_len[d] = rlen[d]; last_rise[d] = rrise[d];
            if (d == 0) hist_a.push_back(rword[d]); else hist_b.push_back(rword[d]);
            rlen[d] = 0; rrise[d] = 0; rword[d] = '0; rlow[d] = 0;
          end
          if (done[d]) done_cnt[d]++;
          psclk[d] = sclk[d]; psen[d] = sen[d];
        end
      end
    end
  end

  // Enter and leave at posedge+1.
  task automatic send(input int d, input logic [47:0] w, output int waited);
    dat[d] = w; vld[d] = 1'b1; waited = 0;
    while (!rdy[d] && waited < 3000) begin @(posedge sys_clk); #1; waited++; end
    chk("accept_seen", rdy[d], 1'b1);
    @(posedge sys_clk); #1; waited++;
  endtask

  task automatic wait_done(input int d, input bit scramble);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk); n++;
      if (scramble) dat[d] = {$urandom, $urandom};
    end while (!done[d] && n < 3000);
    chk("done_seen", done[d], 1'b1);
    @(negedge sys_clk); @(posedge sys_clk); #1;
  endtask

  initial begin
    int w, dc;
    // Reset: valid wiggles, pins must stay idle and ready low.
    repeat (4) begin @(posedge sys_clk); #1; vld = ~vld; end
    @(negedge sys_clk); #1;
    chk("rst_lit_a", {sen[0], sclk[0], sdata[0], rdy[0], done[0]}, 5'b00100);
    chk("rst_lit_b", {sen[1], sclk[1], sdata[1], rdy[1], done[1]}, 5'b00100);
    vld = '0;
    @(negedge sys_clk); #1; rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("ready_after_release", rdy, 2'b11);

    // Single frame with tx_data scrambled mid-frame.
    dc = done_cnt[0];
    send(0, 48'h8000_0100_0009, w); vld[0] = 0;
    wait_done(0, 1'b1);
    chk("single_len", last_len[0], 964);
    chk("single_rises", last_rise[0], 48);
    chk("single_word", hist_a.pop_front(), 48'h8000_0100_0009);
    chk("single_done_cnt", done_cnt[0] - dc, 1);

    // Back-to-back with valid held.
    send(0, 48'h1234_5678_9ABC, w);
    send(0, 48'hFEDC_BA98_7654, w);
    chk("accept_to_accept", w, 970);
    vld[0] = 0;
    wait_done(0, 1'b1);
    chk("b2b_word1", hist_a.pop_front(), 48'h1234_5678_9ABC);
    chk("b2b_word2", hist_a.pop_front(), 48'hFEDC_BA98_7654);
    chk("b2b_sen_gap_ge", last_low[0] >= 4, 1'b1);

    // Reset after about 20 bits, then a clean frame.
    send(0, 48'hA5A5_5A5A_0F0F, w); vld[0] = 0;
    repeat (2 + 20 * 20 + 5) @(posedge sys_clk);
    #3 rst_n = 1'b0;
    #1 chk("async_rst_pins", {sen[0], sclk[0], sdata[0]}, 3'b001);
    repeat (3) @(negedge sys_clk);
    #1 rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("abort_no_frame", hist_a.size(), 0);
    send(0, 48'h0000_C0FF_EE01, w); vld[0] = 0;
    wait_done(0, 1'b0);
    chk("post_rst_word", hist_a.pop_front(), 48'h0000_C0FF_EE01);
    chk("post_rst_rises", last_rise[0], 48);

    // All ones with inversion.
    send(0, {48{1'b1}}, w); vld[0] = 0;
    wait_done(0, 1'b0);
    chk("ones_word", hist_a.pop_front(), {48{1'b1}});

    // Small variant: zero word, then a bit-order pattern.
    dc = done_cnt[1];
    send(1, 48'h0, w); vld[1] = 0;
    wait_done(1, 1'b1);
    chk("b_len", last_len[1], 18);
    chk("b_rises", last_rise[1], 8);
    chk("b_zero_word", hist_b.pop_front(), 48'h0);
    send(1, 48'hB4, w); vld[1] = 0;
    wait_done(1, 1'b0);
    chk("b_order_word", hist_b.pop_front(), 48'hB4);
    chk("b_done_cnt", done_cnt[1] - dc, 2);

    // Random traffic on both links, which the per-cycle model checks.
    repeat (4000) begin
      @(posedge sys_clk); #1;
      for (int d = 0; d < 2; d++) begin
        vld[d] = ($urandom_range(0, 3) != 0);
        dat[d] = {$urandom, $urandom};
      end
    end
    vld = '0;
    repeat (1100) @(posedge sys_clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
